sdram_req_arbiter: RTL and testbench
====================================

# sdram_req_arbiter

Arbitrates single-word SDRAM accesses between two requesters (port 0: time-tag capture writer, port 1: USB host command path) and a periodic auto-refresh timer, and presents one access at a time to the downstream SDRAM command engine. Sits between the FX2/capture logic and the SDRAM state machine. It replaces the free-running refresh counter with a scheduled refresh slot. It also guards against a hung engine with a completion watchdog.

## Interface
- ADDR_W, 20, word address width (BA + row + column)
- DATA_W, 16, SDRAM data width
- REFRESH_PERIOD, 256, cycles between refresh requests (≥16)
- TIMEOUT, 64, cycles allowed from dn_req to dn_done
- clk  in  1  system clock (FX2 clock domain)
- rst_n  in  1  asynchronous active-low reset
- p0_req / p1_req  in  1  level request; held until matching ack
- p0_rdwr / p1_rdwr  in  1  1 = read, 0 = write
- p0_addr / p1_addr  in  ADDR_W  word address; stable while req is high
- p0_wdata / p1_wdata  in  DATA_W  write data; stable while req is high
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid in the ack cycle of a read
- dn_req  out  1  one-cycle command pulse to the engine
- dn_kind  out  2  00 write, 01 read, 10 refresh
- dn_addr  out  ADDR_W  latched address
- dn_wdata  out  DATA_W  latched write data
- dn_done  in  1  engine completion pulse
- dn_rdata  in  DATA_W  engine read data, valid with dn_done
- err_timeout  out  1  sticky: watchdog expired
- err_refresh_miss  out  1  sticky: refresh period elapsed while a refresh was still pending

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE, priority order:
  - refresh_pending → latch kind=10 → ISSUE.
  - Otherwise, any pX_req → select a winner, latch its rdwr/addr/wdata and grant id → ISSUE.
  - Otherwise, stay in IDLE.
- ISSUE: dn_req=1 for exactly one cycle; a refresh grant clears refresh_pending; watchdog loads 0; → WAIT.
- WAIT: watchdog increments each cycle.
  - dn_done → capture dn_rdata → DONE.
  - Watchdog reaches TIMEOUT-1 without dn_done → set err_timeout → DONE, with rdata forced to 0.
- DONE: pulse ack to the granted port (no ack for a refresh) → IDLE. Requests are not sampled in DONE, so a requester must drop req or change its request by the next cycle.
- dn_done seen outside WAIT is ignored.
- Refresh timer:
  - Counter 0..REFRESH_PERIOD-1, free-running, wraps to 0.
  - Wrap sets refresh_pending.
  - Wrap while refresh_pending is already 1 sets err_refresh_miss. A simultaneous clear by ISSUE takes precedence: pending stays 1, no miss is flagged.
- Arbitration: last_grant register, updated on port grants only. Refresh does not alter it.

## Timing
- Reset values: all outputs 0; state IDLE; refresh counter 0; refresh_pending 0; last_grant = 1; error flags 0.
- Request sampled in IDLE at edge N → dn_req high in cycle N+1 → dn_done in cycle N+1+L (L ≥ 1) → pX_ack and rdata in cycle N+2+L.
- Minimum turnaround is 4 cycles per access with L=1.
- dn_addr, dn_wdata and dn_kind are held from ISSUE until the next ISSUE.
- rst_n asserted mid-WAIT: the access is abandoned with no ack, and all state returns to reset values immediately.

## Configuration
- SDRAM_ARB_ROUND_ROBIN_EN defined: when both ports request, the port not equal to last_grant wins. A single requester always wins.
- Undefined: fixed priority, port 0 always wins. last_grant is still maintained, but only as a debug register.

## Structure
- Package sdram_arb_pkg holds:
  - the dn_kind encodings KIND_WRITE, KIND_READ, KIND_REFRESH;
  - the FSM state typedef;
  - the grant id typedef.
- Sub-module sdram_refresh_timer holds the counter, refresh_pending and err_refresh_miss. Its interface is tick-in clear / pending-out.
- Arbitration, latching and the watchdog stay in the top module.

## Test plan
- Port 1 write, addr 0x12345, data 0xBEEF, dn_done 3 cycles after dn_req → dn_kind=00, dn_addr=0x12345, dn_wdata=0xBEEF, p1_ack exactly 1 cycle after dn_done, p0_ack stays 0.
- Port 0 read of 0x00010, dn_rdata=0xA5A5 → p0_ack with rdata=0xA5A5 in the same cycle.
- Both ports requesting continuously, L=1:
  - with SDRAM_ARB_ROUND_ROBIN_EN, grants are 0,1,0,1;
  - without it, grants are 0,0,0,0.
- REFRESH_PERIOD=16, ports saturating → a refresh (kind=10, no ack) is issued at the first IDLE after the wrap. Stalling dn_done for more than 16 cycles sets err_refresh_miss.
- TIMEOUT=32, dn_done never returned → err_timeout set after 32 WAIT cycles; requester acked with rdata=0; next request is served normally.
- rst_n pulsed during WAIT, then a late dn_done → no ack, all outputs 0, first post-reset grant goes to port 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arb_pkg
//  Description : Shared encodings and types for the SDRAM request arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam logic [1:0] KIND_WRITE   = 2'b00;
    localparam logic [1:0] KIND_READ    = 2'b01;
    localparam logic [1:0] KIND_REFRESH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_P0 = 1'b0,
        GRANT_P1 = 1'b1
    } grant_id_t;

    function automatic grant_id_t other_port(input grant_id_t g);
        return (g == GRANT_P0) ? GRANT_P1 : GRANT_P0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_req_arbiter_if
//  Description : Requester, engine and status signals of the SDRAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_req_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              p0_req;
    logic              p0_rdwr;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p1_req;
    logic              p1_rdwr;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] rdata;
    logic              dn_req;
    logic [1:0]        dn_kind;
    logic [ADDR_W-1:0] dn_addr;
    logic [DATA_W-1:0] dn_wdata;
    logic              dn_done;
    logic [DATA_W-1:0] dn_rdata;
    logic              err_timeout;
    logic              err_refresh_miss;

    modport slave (
        input  p0_req, p0_rdwr, p0_addr, p0_wdata,
        input  p1_req, p1_rdwr, p1_addr, p1_wdata,
        input  dn_done, dn_rdata,
        output p0_ack, p1_ack, rdata,
        output dn_req, dn_kind, dn_addr, dn_wdata,
        output err_timeout, err_refresh_miss
    );

    modport master (
        output p0_req, p0_rdwr, p0_addr, p0_wdata,
        output p1_req, p1_rdwr, p1_addr, p1_wdata,
        output dn_done, dn_rdata,
        input  p0_ack, p1_ack, rdata,
        input  dn_req, dn_kind, dn_addr, dn_wdata,
        input  err_timeout, err_refresh_miss
    );

endinterface
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_refresh_timer
//  Description : Free-running refresh period counter with pending/miss flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_refresh_timer #(
    parameter int REFRESH_PERIOD = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_clear,
    output logic o_pending,
    output logic o_miss
);
    localparam int CNT_W = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(REFRESH_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_miss;
    logic             w_wrap;

    assign w_wrap = i_tick && (r_cnt == c_CNT_LAST);

    // A wrap re-arms pending even when the same edge clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_miss    <= 1'b0;
        end else begin
            if (i_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end
            if (w_wrap) begin
                r_pending <= 1'b1;
                if (r_pending && !i_clear) begin
                    r_miss <= 1'b1;
                end
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_miss    = r_miss;

endmodule
`default_nettype wire

// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_req_arbiter
//  Description : Two-port SDRAM access arbiter with scheduled refresh and a
//                completion watchdog. SDRAM_ARB_ROUND_ROBIN_EN selects
//                round-robin arbitration; fixed port-0 priority otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 16,
    parameter int REFRESH_PERIOD = 256,
    parameter int TIMEOUT        = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    sdram_req_arbiter_if.slave bus
);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    grant_id_t         r_grant;
    grant_id_t         r_last_grant;
    logic              r_dn_req;
    logic [1:0]        r_kind;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err_timeout;
    logic [WD_W-1:0]   r_wd;

    grant_id_t         w_winner;
    logic              w_sel_rdwr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_port_access;
    logic              w_refresh_pending;
    logic              w_refresh_clear;
    logic              w_refresh_miss;

    sdram_refresh_timer #(
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_tick    (1'b1),
        .i_clear   (w_refresh_clear),
        .o_pending (w_refresh_pending),
        .o_miss    (w_refresh_miss)
    );

    assign w_refresh_clear = (r_state == ST_ISSUE) && (r_kind == KIND_REFRESH);
    assign w_port_access   = (r_kind != KIND_REFRESH);

    // With no requester the previous grant is held; the value is unused then.
    always_comb begin
        w_winner = r_last_grant;
        if (bus.p0_req && bus.p1_req) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            w_winner = other_port(r_last_grant);
`else
            w_winner = GRANT_P0;
`endif
        end else if (bus.p0_req) begin
            w_winner = GRANT_P0;
        end else if (bus.p1_req) begin
            w_winner = GRANT_P1;
        end
    end

    assign w_sel_rdwr  = (w_winner == GRANT_P1) ? bus.p1_rdwr  : bus.p0_rdwr;
    assign w_sel_addr  = (w_winner == GRANT_P1) ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = (w_winner == GRANT_P1) ? bus.p1_wdata : bus.p0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= GRANT_P0;
            r_last_grant  <= GRANT_P1;
            r_dn_req      <= 1'b0;
            r_kind        <= KIND_WRITE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rdata       <= '0;
            r_err_timeout <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_dn_req <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_refresh_pending) begin
                        r_kind   <= KIND_REFRESH;
                        r_dn_req <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end else if (bus.p0_req || bus.p1_req) begin
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_kind       <= w_sel_rdwr ? KIND_READ : KIND_WRITE;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_dn_req     <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.dn_done) begin
                        r_rdata <= bus.dn_rdata;
                        r_ack0  <= w_port_access && (r_grant == GRANT_P0);
                        r_ack1  <= w_port_access && (r_grant == GRANT_P1);
                        r_state <= ST_DONE;
                    end else if (r_wd == c_WD_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_rdata       <= '0;
                        r_ack0        <= w_port_access && (r_grant == GRANT_P0);
                        r_ack1        <= w_port_access && (r_grant == GRANT_P1);
                        r_state       <= ST_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_ack           = r_ack0;
    assign bus.p1_ack           = r_ack1;
    assign bus.rdata            = r_rdata;
    assign bus.dn_req           = r_dn_req;
    assign bus.dn_kind          = r_kind;
    assign bus.dn_addr          = r_addr;
    assign bus.dn_wdata         = r_wdata;
    assign bus.err_timeout      = r_err_timeout;
    assign bus.err_refresh_miss = w_refresh_miss;

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_req_arbiter
//  Description : Scoreboard bench for sdram_req_arbiter with an engine model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_req_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int RP     = 16;
    localparam int TMO    = 32;

    typedef struct {
        logic              rdwr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } preq_t;

    typedef struct {
        int                port;
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    preq_t pq0[$];
    preq_t pq1[$];
    exp_t  exp_q[$];
    int    tb_lg = 1;
    int    tmo_seen = 0;
    int    n_refresh = 0;
    int    issue_cyc = 0;
    int    done_cyc = 0;
    logic [1:0] last_kind = KIND_WRITE;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_req_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .REFRESH_PERIOD (RP),
        .TIMEOUT        (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Refresh reference: counter, pending flag as seen by the last decision edge, miss flag.
    int   m_cnt;
    logic m_pend, m_pend_prev, m_miss;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_pend <= 1'b0; m_pend_prev <= 1'b0; m_miss <= 1'b0;
        end else begin
            m_pend_prev <= m_pend;
            m_cnt       <= (m_cnt == RP - 1) ? 0 : m_cnt + 1;
            if (m_cnt == RP - 1) begin
                m_pend <= 1'b1;
                if (m_pend && !(bus.dn_req && bus.dn_kind == KIND_REFRESH)) m_miss <= 1'b1;
            end else if (bus.dn_req && bus.dn_kind == KIND_REFRESH) begin
                m_pend <= 1'b0;
            end
        end
    end

    // Engine model: completes refreshes after one cycle, port accesses after the expected latency.
    initial begin
        int lat;
        logic [DATA_W-1:0] rd;
        bus.dn_done  = 1'b0;
        bus.dn_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.dn_req) begin
                lat = 1;
                rd  = '0;
                if (bus.dn_kind != KIND_REFRESH && exp_q.size() > 0) begin
                    lat = exp_q[0].lat;
                    rd  = exp_q[0].rdata;
                end
                if (lat > 0) begin
                    repeat (lat) @(posedge clk);
                    #1 bus.dn_done = 1'b1; bus.dn_rdata = rd;
                    @(posedge clk);
                    #1 bus.dn_done = 1'b0; bus.dn_rdata = '0;
                end
            end
        end
    end

    // Monitor: issue and completion checks against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.dn_done) done_cyc = cyc;
                if (bus.dn_req) begin
                    last_kind = bus.dn_kind;
                    issue_cyc = cyc;
                    check_val("refresh_sel", bus.dn_kind == KIND_REFRESH, m_pend_prev);
                    if (bus.dn_kind == KIND_REFRESH) begin
                        n_refresh++;
                    end else begin
                        check_val("issue_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            check_val("dn_kind", bus.dn_kind, exp_q[0].kind);
                            check_val("dn_addr", bus.dn_addr, exp_q[0].addr);
                            check_val("dn_wdata", bus.dn_wdata, exp_q[0].wdata);
                        end
                    end
                end
                if (bus.p0_ack || bus.p1_ack) begin
                    check_val("ack_expected", exp_q.size() > 0, 1);
                    check_val("ack_not_refresh", last_kind != KIND_REFRESH, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        if (e.lat == 0) tmo_seen++;
                        check_val("ack_port", {bus.p1_ack, bus.p0_ack}, (e.port == 1) ? 2'b10 : 2'b01);
                        if (e.kind == KIND_READ)
                            check_val("rdata", bus.rdata, (e.lat == 0) ? '0 : e.rdata);
                        check_val("ack_latency", cyc - issue_cyc, ((e.lat == 0) ? TMO : e.lat) + 1);
                        if (e.lat != 0) check_val("ack_after_done", cyc - done_cyc, 1);
                        check_val("err_timeout", bus.err_timeout, tmo_seen > 0);
                        check_val("err_refresh_miss", bus.err_refresh_miss, m_miss);
                        tb_lg = e.port;
                    end
                end
            end
        end
    end

    task automatic drive_port(input int p, input logic req, input preq_t r);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_rdwr = r.rdwr; bus.p0_addr = r.addr; bus.p0_wdata = r.wdata;
        end else begin
            bus.p1_req = req; bus.p1_rdwr = r.rdwr; bus.p1_addr = r.addr; bus.p1_wdata = r.wdata;
        end
    endtask

    task automatic run_port(input int p);
        preq_t r;
        preq_t z;
        int    guard;
        logic  got;
        z = '{rdwr: 1'b0, addr: '0, wdata: '0, rdata: '0};
        while (((p == 0) ? pq0.size() : pq1.size()) > 0) begin
            if (p == 0) r = pq0[0]; else r = pq1[0];
            drive_port(p, 1'b1, r);
            guard = 0;
            got   = 1'b0;
            while (!got && guard < 2000) begin
                @(negedge clk);
                guard++;
                got = (p == 0) ? bus.p0_ack : bus.p1_ack;
            end
            check_val($sformatf("ack_seen_p%0d", p), got, 1);
            if (!got) begin
                if (p == 0) pq0.delete(); else pq1.delete();
            end else if (p == 0) begin
                void'(pq0.pop_front());
            end else begin
                void'(pq1.pop_front());
            end
        end
        drive_port(p, 1'b0, z);
    endtask

    // Builds the expected grant order from the queued requests, then runs both ports.
    task automatic launch(input int lat);
        int   i0 = 0;
        int   i1 = 0;
        int   lg = tb_lg;
        int   w;
        preq_t r;
        while (i0 < pq0.size() || i1 < pq1.size()) begin
            if (i0 < pq0.size() && i1 < pq1.size()) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                w = (lg == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else begin
                w = (i0 < pq0.size()) ? 0 : 1;
            end
            if (w == 0) begin r = pq0[i0]; i0++; end
            else        begin r = pq1[i1]; i1++; end
            exp_q.push_back('{port: w, kind: r.rdwr ? KIND_READ : KIND_WRITE, addr: r.addr,
                              wdata: r.wdata, rdata: r.rdata, lat: lat});
            lg = w;
        end
        fork
            run_port(0);
            run_port(1);
        join
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_p0_ack"}, bus.p0_ack, 0);
        check_val({tag, "_p1_ack"}, bus.p1_ack, 0);
        check_val({tag, "_rdata"}, bus.rdata, 0);
        check_val({tag, "_dn_req"}, bus.dn_req, 0);
        check_val({tag, "_dn_kind"}, bus.dn_kind, 0);
        check_val({tag, "_dn_addr"}, bus.dn_addr, 0);
        check_val({tag, "_dn_wdata"}, bus.dn_wdata, 0);
        check_val({tag, "_err_timeout"}, bus.err_timeout, 0);
        check_val({tag, "_err_refresh_miss"}, bus.err_refresh_miss, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete by cycle %0d", cyc);
        $fatal(1, "simulation timeout");
    end

    initial begin
        preq_t z;
        int    guard;
        logic  found;
        z = '{rdwr: 1'b0, addr: '0, wdata: '0, rdata: '0};
        drive_port(0, 1'b0, z);
        drive_port(1, 1'b0, z);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pq1.push_back('{rdwr: 1'b0, addr: 20'h12345, wdata: 16'hBEEF, rdata: 16'h1111});
        launch(3);

        pq0.push_back('{rdwr: 1'b1, addr: 20'h00010, wdata: 16'h0000, rdata: 16'hA5A5});
        launch(1);

        for (int k = 0; k < 4; k++) begin
            pq0.push_back('{rdwr: k[0], addr: 20'h40000 + k, wdata: 16'($urandom), rdata: 16'($urandom)});
            pq1.push_back('{rdwr: ~k[0], addr: 20'h80000 + k, wdata: 16'($urandom), rdata: 16'($urandom)});
        end
        launch(1);

        pq0.push_back('{rdwr: 1'b1, addr: 20'h0C0DE, wdata: 16'h0000, rdata: 16'h3C3C});
        launch(30);

        pq1.push_back('{rdwr: 1'b1, addr: 20'h0ABCD, wdata: 16'h0000, rdata: 16'h7777});
        launch(0);
        check_val("miss_after_stall", bus.err_refresh_miss, 1);
        pq0.push_back('{rdwr: 1'b0, addr: 20'h00F00, wdata: 16'h1234, rdata: 16'h0F0F});
        launch(2);

        // Reset in the middle of an access; the engine completes late.
        exp_q.push_back('{port: 1, kind: KIND_READ, addr: 20'h55555, wdata: 16'h0000,
                          rdata: 16'h9999, lat: 8});
        bus.p1_req = 1'b1; bus.p1_rdwr = 1'b1; bus.p1_addr = 20'h55555; bus.p1_wdata = 16'h0000;
        guard = 0;
        found = 1'b0;
        while (!found && guard < 500) begin
            @(negedge clk);
            guard++;
            found = bus.dn_req && (bus.dn_kind != KIND_REFRESH);
        end
        check_val("rst_issue_seen", found, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus.p1_req = 1'b0;
        exp_q.delete();
        tmo_seen = 0;
        tb_lg = 1;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_outputs_zero("post_reset");

        pq0.push_back('{rdwr: 1'b0, addr: 20'h01111, wdata: 16'hCAFE, rdata: 16'h0000});
        pq1.push_back('{rdwr: 1'b1, addr: 20'h02222, wdata: 16'h0000, rdata: 16'h6B6B});
        launch(1);

        check_val("refresh_seen", n_refresh > 0, 1);
        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
